hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/haz_pkg.sv | 52 +++++
 rtl/haz_mdu_timer.sv | 44 ++++
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/haz_pkg.sv
// Shared hazard-control types: forwarding select codes, stage shadow entries,
// and small helpers for register matching and tNew ageing.
package haz_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TNEW_W = 2;
    localparam int unsigned SEL_W  = 2;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [TNEW_W-1:0] tnew_t;
    typedef logic [SEL_W-1:0]  fwd_sel_t;

    // Operand source select codes
    localparam fwd_sel_t FWD_NONE = 2'd0;   // GRF / pipeline value
    localparam fwd_sel_t FWD_E    = 2'd1;   // E-stage result
    localparam fwd_sel_t FWD_M    = 2'd2;   // M-stage result
    localparam fwd_sel_t FWD_W    = 2'd3;   // W-stage result

    // E-stage shadow entry (full set of fields)
    typedef struct packed {
        reg_idx_t rs;
        reg_idx_t rt;
        reg_idx_t wa;
        logic     we;
        tnew_t    tnew;
    } stage_entry_t;

    // M-stage shadow entry: rs is no longer needed past E
    typedef struct packed {
        reg_idx_t rt;
        reg_idx_t wa;
        logic     we;
        tnew_t    tnew;
    } m_entry_t;

    // W-stage shadow entry: result is always ready here
    typedef struct packed {
        reg_idx_t wa;
        logic     we;
    } w_entry_t;

    // An in-flight writer matches a source only for a nonzero register
    function automatic logic entry_hit(input logic we, input reg_idx_t wa, input reg_idx_t r);
        return we && (wa == r) && (r != '0);
    endfunction

    // tNew moves one stage closer to ready, saturating at zero
    function automatic tnew_t tnew_age(input tnew_t t);
        return (t == '0) ? '0 : (t - tnew_t'(1));
    endfunction

endpackage

// File: rtl/haz_mdu_timer.sv
// Multiply/divide busy timer: loads the operation latency on start,
// counts down to zero, and reports busy while a result is outstanding.
module haz_mdu_timer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam int unsigned MAX_CYC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a start (re)loads the latency, otherwise count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Busy covers the start cycle itself plus every nonzero count
    always_comb begin
        busy = start | (cnt_q != '0);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows the E/M/W destination info, raises a
// load-use style stall from tUse/tNew, and picks forwarding sources for the
// D, E and M stage operands. Optional MDU busy interlock under HAZARD_MDU_EN.
module hazard_ctrl
    import haz_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  d_rs,
    input  logic [REG_W-1:0]  d_rt,
    input  logic              d_re_rs,
    input  logic              d_re_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic [REG_W-1:0]  d_wa,
    input  logic              d_we,
    input  logic [TNEW_W-1:0] d_tnew,
`ifdef HAZARD_MDU_EN
    input  logic              mdu_start_e,
    input  logic              mdu_div_e,
    input  logic              d_mdu_use,
    output logic              mdu_busy,
`endif
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_d_rs,
    output logic [SEL_W-1:0]  fwd_d_rt,
    output logic [SEL_W-1:0]  fwd_e_rs,
    output logic [SEL_W-1:0]  fwd_e_rt,
    output logic [SEL_W-1:0]  fwd_m_rt
);

    stage_entry_t e_q, e_d;
    m_entry_t     m_q, m_d;
    w_entry_t     w_q, w_d;

    logic e_hit_rs, e_hit_rt;
    logic m_hit_rs, m_hit_rt;
    logic w_hit_rs, w_hit_rt;
    logic em_hit_rs, em_hit_rt;
    logic ew_hit_rs, ew_hit_rt;
    logic mw_hit_rt;
    logic haz_stall;

    // D-stage select: youngest ready producer wins, W is always ready
    function automatic fwd_sel_t d_sel(input logic e_hit, input tnew_t e_tnew,
                                       input logic m_hit, input tnew_t m_tnew,
                                       input logic w_hit);
        fwd_sel_t sel;
        sel = FWD_NONE;
        if (e_hit && (e_tnew == '0)) begin
            sel = FWD_E;
        end else if (m_hit && (m_tnew == '0)) begin
            sel = FWD_M;
        end else if (w_hit) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    // E-stage select: only M and W are older than an E operand
    function automatic fwd_sel_t e_sel(input logic m_hit, input tnew_t m_tnew, input logic w_hit);
        fwd_sel_t sel;
        sel = FWD_NONE;
        if (m_hit && (m_tnew == '0)) begin
            sel = FWD_M;
        end else if (w_hit) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    // Source-vs-stage match vectors
    always_comb begin
        e_hit_rs  = entry_hit(e_q.we, e_q.wa, d_rs);
        e_hit_rt  = entry_hit(e_q.we, e_q.wa, d_rt);
        m_hit_rs  = entry_hit(m_q.we, m_q.wa, d_rs);
        m_hit_rt  = entry_hit(m_q.we, m_q.wa, d_rt);
        w_hit_rs  = entry_hit(w_q.we, w_q.wa, d_rs);
        w_hit_rt  = entry_hit(w_q.we, w_q.wa, d_rt);
        em_hit_rs = entry_hit(m_q.we, m_q.wa, e_q.rs);
        em_hit_rt = entry_hit(m_q.we, m_q.wa, e_q.rt);
        ew_hit_rs = entry_hit(w_q.we, w_q.wa, e_q.rs);
        ew_hit_rt = entry_hit(w_q.we, w_q.wa, e_q.rt);
        mw_hit_rt = entry_hit(w_q.we, w_q.wa, m_q.rt);
    end

    // Data hazard stall: a matching producer will not be ready by the time D needs it
    always_comb begin
        haz_stall = 1'b0;
        if (d_re_rs && ((e_hit_rs && (e_q.tnew > d_tuse_rs)) ||
                        (m_hit_rs && (m_q.tnew > d_tuse_rs)))) begin
            haz_stall = 1'b1;
        end
        if (d_re_rt && ((e_hit_rt && (e_q.tnew > d_tuse_rt)) ||
                        (m_hit_rt && (m_q.tnew > d_tuse_rt)))) begin
            haz_stall = 1'b1;
        end
    end

`ifdef HAZARD_MDU_EN
    haz_mdu_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_timer (
        .clk   (clk),
        .reset (reset),
        .start (mdu_start_e),
        .div   (mdu_div_e),
        .busy  (mdu_busy)
    );

    // Combined stall: data hazard or an HI/LO reader while the MDU is busy
    always_comb begin
        stall = ~reset & (haz_stall | (d_mdu_use & mdu_busy));
    end
`else
    // Combined stall: data hazard only
    always_comb begin
        stall = ~reset & haz_stall;
    end
`endif

    // Forwarding selects for all three consuming stages
    always_comb begin
        fwd_d_rs = d_sel(e_hit_rs, e_q.tnew, m_hit_rs, m_q.tnew, w_hit_rs);
        fwd_d_rt = d_sel(e_hit_rt, e_q.tnew, m_hit_rt, m_q.tnew, w_hit_rt);
        fwd_e_rs = e_sel(em_hit_rs, m_q.tnew, ew_hit_rs);
        fwd_e_rt = e_sel(em_hit_rt, m_q.tnew, ew_hit_rt);
        fwd_m_rt = mw_hit_rt ? FWD_W : FWD_NONE;
    end

    // Next shadow entries: stall drops a bubble into E, M and W always advance
    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.rs   = d_rs;
            e_d.rt   = d_rt;
            e_d.wa   = d_wa;
            e_d.we   = d_we;
            e_d.tnew = d_tnew;
        end
        m_d.rt   = e_q.rt;
        m_d.wa   = e_q.wa;
        m_d.we   = e_q.we;
        m_d.tnew = tnew_age(e_q.tnew);
        w_d.wa   = m_q.wa;
        w_d.we   = m_q.we;
    end

    // Stage shadow registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

endmodule
